ram_arbiter: RTL and testbench

Sequences and shares the single-port RAM between N_REQ requesters, e.g. the SPI slave path and a local host/DMA port. Each requester issues whole transactions (write addr+data, or read addr). The block turns each into the RAM's 10-bit command protocol on ram_din/ram_rx_valid and routes ram_dout back on ram_tx_valid. Arbitration is round-robin, and only one transaction is in flight at a time.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arbiter_rr_arbiter.sv | 32 +++
 rtl/ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM states and the RAM command codes
// carried in the top two bits of ram_din.
package ram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_CMD,
      RD_WAIT
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/ram_arbiter_rr_arbiter.sv
// Round-robin picker: first requesting index after the last grant, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
   parameter int N_REQ = 2,
   localparam int IW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   input  logic [IW-1:0]    last,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(last) + k) % N_REQ);
         if (en && !found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port command RAM between N_REQ requesters, round-robin.
// Optional read watchdog with rsp_err output: define RAM_ARB_TIMEOUT_EN.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0]             req_wr,
   input  logic [N_REQ*ADDR_SIZE-1:0]   req_addr,
   input  logic [N_REQ*ADDR_SIZE-1:0]   req_wdata,
   output logic [N_REQ-1:0]             req_ready,
   output logic [N_REQ-1:0]             rsp_valid,
   output logic [ADDR_SIZE-1:0]         rsp_rdata,
`ifdef RAM_ARB_TIMEOUT_EN
   output logic                         rsp_err,
`endif
   output logic [ADDR_SIZE+1:0]         ram_din,
   output logic                         ram_rx_valid,
   input  logic                         ram_tx_valid,
   input  logic [ADDR_SIZE-1:0]         ram_dout
);

   localparam int IW = $clog2(N_REQ);

   state_t                 state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [N_REQ-1:0]       owner_q, owner_d;
   logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
   logic [ADDR_SIZE+1:0]   din_q, din_d;
   logic                   rxv_q, rxv_d;
   logic [N_REQ-1:0]       rspv_q, rspv_d;
   logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
   logic [N_REQ-1:0]       gnt_vec;
   logic [IW-1:0]          gnt_idx;
   logic                   arb_en;
   logic                   sel_wr;
   logic [ADDR_SIZE-1:0]   sel_addr;
   logic [ADDR_SIZE-1:0]   sel_wdata;

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   assign arb_en = (state_q == IDLE) && !rst;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req   (req_valid),
      .en    (arb_en),
      .last  (ptr_q),
      .grant (gnt_vec),
      .idx   (gnt_idx)
   );

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_wr    = req_wr[i];
            sel_addr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
            sel_wdata = req_wdata[i*ADDR_SIZE +: ADDR_SIZE];
         end
      end
   end

   // RAM-side outputs are computed for the state being entered so they
   // leave the flops aligned with that state.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      wdata_d   = wdata_q;
      din_d     = '0;
      rxv_d     = 1'b0;
      rspv_d    = '0;
      rdata_d   = rdata_q;
      req_ready = '0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_d     = '0;
      err_d     = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (|gnt_vec) begin
               req_ready = gnt_vec;
               ptr_d     = gnt_idx;
               owner_d   = gnt_vec;
               wdata_d   = sel_wdata;
               rxv_d     = 1'b1;
               if (sel_wr) begin
                  state_d = WR_ADDR;
                  din_d   = {CMD_WR_ADDR, sel_addr};
               end else begin
                  state_d = RD_ADDR;
                  din_d   = {CMD_RD_ADDR, sel_addr};
               end
            end
         end
         WR_ADDR: begin
            state_d = WR_DATA;
            rxv_d   = 1'b1;
            din_d   = {CMD_WR_DATA, wdata_q};
         end
         WR_DATA: state_d = IDLE;
         RD_ADDR: begin
            state_d = RD_CMD;
            rxv_d   = 1'b1;
            din_d   = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
         end
         RD_CMD: state_d = RD_WAIT;
         RD_WAIT: begin
            if (ram_tx_valid) begin
               state_d = IDLE;
               rspv_d  = owner_q;
               rdata_d = ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               rspv_d  = owner_q;
               rdata_d = {ADDR_SIZE{1'b1}};
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(N_REQ - 1);
         owner_q <= '0;
         wdata_q <= '0;
         din_q   <= '0;
         rxv_q   <= 1'b0;
         rspv_q  <= '0;
         rdata_q <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         wdata_q <= wdata_d;
         din_q   <= din_d;
         rxv_q   <= rxv_d;
         rspv_q  <= rspv_d;
         rdata_q <= rdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign ram_din      = din_q;
   assign ram_rx_valid = rxv_q;
   assign rsp_valid    = rspv_q;
   assign rsp_rdata    = rdata_q;
`ifdef RAM_ARB_TIMEOUT_EN
   assign rsp_err      = err_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model plus directed scenarios.
// Also exercises the read watchdog when RAM_ARB_TIMEOUT_EN is defined.
module tb_ram_arbiter;

   localparam int N  = 2;
   localparam int AS = 8;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_wr;
   logic [N*AS-1:0] req_addr, req_wdata;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [AS-1:0]   rsp_rdata;
   logic [AS+1:0]   ram_din;
   logic            ram_rx_valid, ram_tx_valid;
   logic [AS-1:0]   ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
   logic            rsp_err;
`endif

   logic tx_m, tx_force, ram_silent;
   int   ram_lat;
   int   n_chk = 0;
   int   n_fail = 0;

   assign ram_tx_valid = tx_m | tx_force;

   always #5 clk = ~clk;

   ram_arbiter #(.N_REQ(N), .ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
`ifdef RAM_ARB_TIMEOUT_EN
      .rsp_err      (rsp_err),
`endif
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_tx_valid (ram_tx_valid),
      .ram_dout     (ram_dout)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Transaction model: pending RAM beats, outstanding read, response slot.
   logic [AS+1:0] beats[$];
   bit            await_rd = 0;
   int            who = 0;
   int            wcnt = 0;
   int            last = N - 1;
   logic [N-1:0]  cur_rspv = '0;
   logic [AS-1:0] cur_rd = '0;
   bit            cur_err = 0;
   int            glog[$];
   logic [AS-1:0] rlog[$];

   always @(negedge clk) begin : model
      logic [N-1:0] er;
      bit           free;
      bit           waiting;
      int           p;
      logic [AS-1:0] a;
      free = (beats.size() == 0) && !await_rd;
      p    = pick(req_valid, last);
      er   = '0;
      if (!rst && free && p >= 0) er[p] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("ram_rx_valid", 32'(ram_rx_valid), 32'(beats.size() != 0));
      chk("ram_din", 32'(ram_din), 32'(beats.size() != 0 ? beats[0] : '0));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur_rspv));
      if (cur_rspv != 0) chk("rsp_rdata", 32'(rsp_rdata), 32'(cur_rd));
`ifdef RAM_ARB_TIMEOUT_EN
      chk("rsp_err", 32'(rsp_err), 32'(cur_err));
`endif
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      if (rsp_valid[1]) rlog.push_back(rsp_rdata);
      if (rst) begin
         beats.delete();
         await_rd = 0;
         cur_rspv = '0;
         cur_err  = 0;
         wcnt     = 0;
         last     = N - 1;
      end else begin
         waiting = await_rd && (beats.size() == 0);
         if (beats.size() != 0) void'(beats.pop_front());
         cur_rspv = '0;
         cur_err  = 0;
         if (waiting) begin
            if (ram_tx_valid) begin
               cur_rspv      = '0;
               cur_rspv[who] = 1'b1;
               cur_rd        = ram_dout;
               await_rd      = 0;
`ifdef RAM_ARB_TIMEOUT_EN
            end else if (wcnt == TO - 1) begin
               cur_rspv[who] = 1'b1;
               cur_rd        = 8'hFF;
               cur_err       = 1;
               await_rd      = 0;
            end else begin
               wcnt++;
`endif
            end
         end
         if (free && p >= 0) begin
            last = p;
            a    = req_addr[p*AS +: AS];
            if (req_wr[p]) begin
               beats.push_back({2'b00, a});
               beats.push_back({2'b01, req_wdata[p*AS +: AS]});
            end else begin
               beats.push_back({2'b10, a});
               beats.push_back({2'b11, 8'h00});
               await_rd = 1;
               who      = p;
               wcnt     = 0;
            end
         end
      end
   end

   // RAM behavioural model responding ram_lat cycles after the RD_DATA beat.
   initial begin : ram
      logic [AS-1:0] mem [256];
      logic [AS-1:0] a;
      int pend;
      pend = 0;
      a = '0;
      tx_m = 1'b0;
      ram_dout = '0;
      forever begin
         @(negedge clk);
         if (ram_rx_valid) begin
            case (ram_din[AS+1:AS])
               2'b00: a = ram_din[AS-1:0];
               2'b01: mem[a] = ram_din[AS-1:0];
               2'b10: a = ram_din[AS-1:0];
               default: pend = ram_lat;
            endcase
         end
         @(posedge clk);
         #1;
         tx_m = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && !ram_silent) begin
               tx_m = 1'b1;
               ram_dout = mem[a];
            end
         end
      end
   end

   task automatic issue(int i, bit wr, logic [AS-1:0] a, logic [AS-1:0] d);
      bit ok = 0;
      req_wr[i] = wr;
      req_addr[i*AS +: AS] = a;
      req_wdata[i*AS +: AS] = d;
      req_valid[i] = 1'b1;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clk);
         ok = req_ready[i];
      end
      chk("accept_wait", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_valid = 2'b11;
      req_wr = 2'b01;
      req_addr = 16'h1234;
      req_wdata = 16'h5678;
      tx_force = 1'b0;
      ram_silent = 1'b0;
      ram_lat = 1;

      repeat (2) begin
         @(negedge clk);
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_ram", 32'({ram_rx_valid, ram_din}), 32'd0);
         chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = '0;

      issue(0, 1'b1, 8'h3C, 8'hA5);
      chk("t2_beat1", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h03C}));
      @(posedge clk); #1;
      chk("t2_beat2", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h1A5}));
      @(posedge clk); #1;
      chk("t2_idle", 32'({ram_rx_valid, rsp_valid}), 32'd0);

      issue(1, 1'b0, 8'h3C, 8'h00);
      chk("t3_beat1", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h23C}));
      @(posedge clk); #1;
      chk("t3_beat2", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h300}));
      @(posedge clk); #1;
      chk("t3_wait", 32'({ram_rx_valid, rsp_valid}), 32'd0);
      @(posedge clk); #1;
      chk("t3_rsp", 32'({rsp_valid, rsp_rdata}), 32'({2'b10, 8'hA5}));
      @(posedge clk); #1;
      chk("t3_rsp_end", 32'(rsp_valid), 32'd0);

      glog.delete();
      rlog.delete();
      ram_lat = 3;
      fork
         begin
            issue(0, 1'b1, 8'h10, 8'h55);
            issue(0, 1'b1, 8'h11, 8'h66);
         end
         begin
            issue(1, 1'b0, 8'h10, 8'h00);
            issue(1, 1'b0, 8'h11, 8'h00);
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("t4_ngrants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("t4_grant", 32'(glog[i]), 32'(i % 2));
      chk("t4_nrsp", 32'(rlog.size()), 32'd2);
      chk("t4_rd0", 32'(rlog[0]), 32'h55);
      chk("t4_rd1", 32'(rlog[1]), 32'h66);

      ram_lat = 1;
      ram_silent = 1'b1;
      issue(0, 1'b0, 8'h3C, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tx_force = 1'b1;
      @(posedge clk); #1;
      tx_force = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t5_quiet", 32'({rsp_valid, ram_rx_valid}), 32'd0);
      end
      ram_silent = 1'b0;
      glog.delete();
      fork
         issue(1, 1'b0, 8'h10, 8'h00);
         issue(0, 1'b0, 8'h11, 8'h00);
      join
      repeat (8) @(posedge clk);
      #1;
      chk("t5_first", 32'(glog[0]), 32'd0);
      chk("t5_second", 32'(glog[1]), 32'd1);

`ifdef RAM_ARB_TIMEOUT_EN
      ram_silent = 1'b1;
      issue(0, 1'b0, 8'h20, 8'h00);
      begin
         int n;
         for (n = 1; n <= TO + 8; n++) begin
            @(negedge clk);
            if (rsp_valid != 0) break;
         end
         chk("t6_latency", 32'(n), 32'(TO + 3));
         chk("t6_rsp", 32'({rsp_err, rsp_rdata, rsp_valid}),
             32'({1'b1, 8'hFF, 2'b01}));
      end
      ram_silent = 1'b0;
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
